// File: rtl/pam4_pkg.sv
// pam4_pkg: shared symbol/state types and the nominal PAM-4 level helper
package pam4_pkg;
  typedef logic [1:0] symbol_t;
  typedef enum logic {ACQUIRE, TRACK} slicer_state_t;
  function automatic int nominal_level(input int r, input int sep, input int k);
    return (1 << (r - 1)) + ((2 * k - 3) * sep) / 2;
  endfunction
endpackage

// File: rtl/pam4_adaptive_slicer_if.sv
// pam4_adaptive_slicer_if: sample input and decision output bundle
interface pam4_adaptive_slicer_if #(parameter int R = 8);
  import pam4_pkg::*;
  logic [R-1:0] voltage_level_in;
  logic voltage_level_in_valid;
  symbol_t symbol_out;
  logic symbol_out_valid;
  modport master(output voltage_level_in, voltage_level_in_valid, input symbol_out, symbol_out_valid);
  modport slave(input voltage_level_in, voltage_level_in_valid, output symbol_out, symbol_out_valid);
endinterface

// File: rtl/pam4_level_tracker.sv
// pam4_level_tracker: one fixed-point level estimate with shift-step adaptation
module pam4_level_tracker #(
  parameter int R = 8,
  parameter int FRAC_BITS = 4,
  parameter int MU_ACQ = 2,
  parameter int MU_TRK = 5,
  parameter int NOM = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic update,
  input  logic acq,
  input  logic [R-1:0] x,
  output logic [R+FRAC_BITS-1:0] level,
  output logic [R-1:0] next_int
);
  localparam int W = R + FRAC_BITS;
  logic signed [W:0] e, step;
  logic [W-1:0] level_nxt;
  always_comb begin
    e = $signed({1'b0, x, {FRAC_BITS{1'b0}}}) - $signed({1'b0, level});
    step = acq ? e >>> MU_ACQ : e >>> MU_TRK;
    // modular add is exact: the estimate never leaves range
    level_nxt = update ? level + W'(step) : level;
  end
  assign next_int = level_nxt[W-1:FRAC_BITS];
  always_ff @(posedge clk)
    if (rst || reload) level <= W'(NOM * (1 << FRAC_BITS));
    else level <= level_nxt;
endmodule

// File: rtl/pam4_adaptive_slicer.sv
// pam4_adaptive_slicer: adaptive PAM-4 decision with acquire/track lock FSM.
// Define PAM4_SLICER_STATS_EN to add per-symbol and relock counters.
module pam4_adaptive_slicer
  import pam4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int FRAC_BITS = 4,
  parameter int MU_ACQ = 2,
  parameter int MU_TRK = 5,
  parameter int ACQ_LEN = 64,
  parameter int MIN_GAP = 16
) (
  input  logic clk,
  input  logic rst,
  pam4_adaptive_slicer_if.slave bus,
  output logic locked,
  output logic [4*(SIGNAL_RESOLUTION+FRAC_BITS)-1:0] level_est
`ifdef PAM4_SLICER_STATS_EN
  ,
  output logic [3:0][31:0] sym_count,
  output logic [15:0] relock_count
`endif
);
  localparam int R = SIGNAL_RESOLUTION;
  localparam int W = R + FRAC_BITS;
  localparam int CW = $clog2(ACQ_LEN + 1);
  slicer_state_t state;
  logic [CW-1:0] acq_cnt;
  logic [W-1:0] lvl [4];
  logic [R-1:0] ln [4];
  logic [R-1:0] li [4];
  logic [R-1:0] t [3];
  logic [R-1:0] x;
  symbol_t sym;
  logic valid, trk, viol, relock;
  assign x = bus.voltage_level_in;
  assign valid = bus.voltage_level_in_valid;
  assign trk = state == TRACK;
  assign relock = valid && trk && viol;
  always_comb begin
    viol = 1'b0;
    for (int k = 0; k < 4; k++) li[k] = lvl[k][W-1:FRAC_BITS];
    for (int k = 0; k < 3; k++) begin
      t[k] = R'((({1'b0, li[k]} + {1'b0, li[k+1]})) >> 1);
      if (int'(ln[k+1]) - int'(ln[k]) < MIN_GAP) viol = 1'b1;
    end
    // ties resolve upward: x == t[k] decides k+1
    sym = x < t[0] ? 2'd0 : x < t[1] ? 2'd1 : x < t[2] ? 2'd2 : 2'd3;
  end
  for (genvar k = 0; k < 4; k++) begin : g_trk
    pam4_level_tracker #(
      .R(R), .FRAC_BITS(FRAC_BITS), .MU_ACQ(MU_ACQ), .MU_TRK(MU_TRK),
      .NOM(nominal_level(R, SYMBOL_SEPERATION, k))
    ) u_trk (
      .clk(clk), .rst(rst), .reload(relock), .update(valid && sym == 2'(k)),
      .acq(!trk), .x(x), .level(lvl[k]), .next_int(ln[k])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ACQUIRE;
      acq_cnt <= '0;
      bus.symbol_out <= '0;
      bus.symbol_out_valid <= 1'b0;
    end else begin
      bus.symbol_out_valid <= valid && trk;
      if (valid && trk) bus.symbol_out <= sym;
      if (valid && !trk) begin
        acq_cnt <= acq_cnt + 1'b1;
        if (acq_cnt == CW'(ACQ_LEN - 1)) state <= TRACK;
      end
      if (relock) begin
        state <= ACQUIRE;
        acq_cnt <= '0;
      end
    end
  assign locked = trk;
  assign level_est = {lvl[3], lvl[2], lvl[1], lvl[0]};
`ifdef PAM4_SLICER_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      sym_count <= '0;
      relock_count <= '0;
    end else if (valid && trk) begin
      if (sym_count[sym] != '1) sym_count[sym] <= sym_count[sym] + 1'b1;
      if (viol && relock_count != '1) relock_count <= relock_count + 1'b1;
    end
`endif
endmodule
